// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding, host-port
// byte strides and a word-index to byte-address helper.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_I,
      S_LOAD_D,
      S_RUN,
      S_DUMP_RD,
      S_DUMP_OUT,
      S_DONE
   } state_t;

   localparam int unsigned IMEM_STRIDE = 4;  // 32-bit instruction words
   localparam int unsigned DMEM_STRIDE = 8;  // 64-bit data words

   // Zero-extended byte address of a word index.
   function automatic logic [63:0] byte_addr(input logic [31:0] idx, input int unsigned stride);
      return {32'd0, idx} * 64'(stride);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_run_counter.sv
// Loadable down-counter that times the RUN phase; zero flags exhaustion.
module run_counter
   import cpu_ctrl_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load takes priority; decrement saturates at zero.
   always_ff @(posedge clk) begin
      if (rst)                   cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer for a CPU under test: streams instruction and data
// words into memory, releases CPU reset and enables it for a fixed number of
// cycles, then reads the data memory back out through a ready/valid stream.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int IMEM_AW = 9,
   parameter int DMEM_AW = 10,
   parameter int RUN_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [IMEM_AW:0]   imem_cnt,
   input  logic [DMEM_AW:0]   dmem_cnt,
   input  logic [RUN_W-1:0]   run_cycles,
   input  logic               ld_valid,
   input  logic [63:0]        ld_data,
   output logic               ld_ready,
   output logic               dump_valid,
   output logic [63:0]        dump_data,
   input  logic               dump_ready,
   output logic               cpu_arst_n,
   output logic               cpu_enable,
   output logic [63:0]        addr_ext,
   output logic               wen_ext,
   output logic               ren_ext,
   output logic [31:0]        wdata_ext,
   output logic [63:0]        addr_ext_2,
   output logic               wen_ext_2,
   output logic               ren_ext_2,
   output logic [63:0]        wdata_ext_2,
   input  logic [63:0]        rdata_ext_2,
   output logic               busy,
   output logic               done
);

   // One index serves both memories, wide enough for a full count of either.
   localparam int IDX_W = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

   state_t             state, nxt;
   logic [IDX_W-1:0]   idx, idx_nxt, idx_inc;
   logic [IMEM_AW:0]   imem_cnt_q;
   logic [DMEM_AW:0]   dmem_cnt_q;
   logic [RUN_W-1:0]   run_q;
   logic [63:0]        dbuf;
   logic               cap_q;     // first DUMP_OUT cycle: read data arriving now
   logic               latch;
   logic               rc_load;
   logic               rc_zero;
   logic               last_i, last_d;

   assign idx_inc = idx + 1'b1;
   assign last_i  = (idx_inc == IDX_W'(imem_cnt_q));
   assign last_d  = (idx_inc == IDX_W'(dmem_cnt_q));

   run_counter #(.W(RUN_W)) u_run_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (rc_load),
      .load_val (run_q),
      .dec      (cpu_enable),
      .zero     (rc_zero)
   );

   // State, word index, latched job parameters and dump buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         imem_cnt_q <= '0;
         dmem_cnt_q <= '0;
         run_q      <= '0;
         dbuf       <= '0;
         cap_q      <= 1'b0;
      end else begin
         state <= nxt;
         idx   <= idx_nxt;
         cap_q <= (state == S_DUMP_RD);
         if (cap_q) dbuf <= rdata_ext_2;
         if (latch) begin
            imem_cnt_q <= imem_cnt;
            dmem_cnt_q <= dmem_cnt;
            run_q      <= run_cycles;
         end
      end
   end

   // Next-state and output decode; everything is forced quiet while rst is high.
   always_comb begin
      nxt         = state;
      idx_nxt     = idx;
      latch       = 1'b0;
      rc_load     = 1'b0;
      ld_ready    = 1'b0;
      dump_valid  = 1'b0;
      dump_data   = '0;
      cpu_arst_n  = 1'b0;
      cpu_enable  = 1'b0;
      addr_ext    = '0;
      wen_ext     = 1'b0;
      ren_ext     = 1'b0;
      wdata_ext   = '0;
      addr_ext_2  = '0;
      wen_ext_2   = 1'b0;
      ren_ext_2   = 1'b0;
      wdata_ext_2 = '0;
      busy        = 1'b0;
      done        = 1'b0;
      if (!rst) begin
         case (state)
            S_IDLE, S_DONE: begin
               done       = (state == S_DONE);
               cpu_arst_n = (state == S_DONE);
               if (start) begin
                  latch   = 1'b1;
                  idx_nxt = '0;
                  nxt     = S_LOAD_I;
               end
            end
            S_LOAD_I: begin
               busy = 1'b1;
               if (imem_cnt_q == '0) begin
                  nxt = S_LOAD_D;
               end else begin
                  ld_ready = 1'b1;
                  if (ld_valid) begin
                     wen_ext   = 1'b1;
                     wdata_ext = ld_data[31:0];
                     addr_ext  = byte_addr(32'(idx), IMEM_STRIDE);
                     if (last_i) begin
                        idx_nxt = '0;
                        nxt     = S_LOAD_D;
                     end else begin
                        idx_nxt = idx_inc;
                     end
                  end
               end
            end
            S_LOAD_D: begin
               busy = 1'b1;
               if (dmem_cnt_q == '0) begin
                  rc_load = 1'b1;
                  nxt     = S_RUN;
               end else begin
                  ld_ready = 1'b1;
                  if (ld_valid) begin
                     wen_ext_2   = 1'b1;
                     wdata_ext_2 = ld_data;
                     addr_ext_2  = byte_addr(32'(idx), DMEM_STRIDE);
                     if (last_d) begin
                        idx_nxt = '0;
                        rc_load = 1'b1;
                        nxt     = S_RUN;
                     end else begin
                        idx_nxt = idx_inc;
                     end
                  end
               end
            end
            S_RUN: begin
               busy       = 1'b1;
               cpu_arst_n = 1'b1;
               if (!rc_zero) cpu_enable = 1'b1;
               else          nxt = (dmem_cnt_q == '0) ? S_DONE : S_DUMP_RD;
            end
            S_DUMP_RD: begin
               busy       = 1'b1;
               cpu_arst_n = 1'b1;
               ren_ext_2  = 1'b1;
               addr_ext_2 = byte_addr(32'(idx), DMEM_STRIDE);
               nxt        = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
               busy       = 1'b1;
               cpu_arst_n = 1'b1;
               dump_valid = 1'b1;
               // Read data is passed straight through on its arrival cycle and
               // held from the buffer afterwards, so the beat never changes.
               dump_data  = cap_q ? rdata_ext_2 : dbuf;
               if (dump_ready) begin
                  if (last_d) begin
                     idx_nxt = '0;
                     nxt     = S_DONE;
                  end else begin
                     idx_nxt = idx_inc;
                     nxt     = S_DUMP_RD;
                  end
               end
            end
            default: nxt = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized scoreboard bench for cpu_run_ctrl with a data memory and a toy
// CPU (increments data words while enabled) in the environment.
module tb_cpu_run_ctrl;

   localparam int IAW = 3;
   localparam int DAW = 3;
   localparam int RW  = 8;

   logic           clk = 1'b0;
   logic           rst, start;
   logic [IAW:0]   imem_cnt;
   logic [DAW:0]   dmem_cnt;
   logic [RW-1:0]  run_cycles;
   logic           ld_valid, ld_ready;
   logic [63:0]    ld_data;
   logic           dump_valid, dump_ready;
   logic [63:0]    dump_data;
   logic           cpu_arst_n, cpu_enable;
   logic [63:0]    addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
   logic           wen_ext, ren_ext, wen_ext_2, ren_ext_2;
   logic [31:0]    wdata_ext;
   logic           busy, done;

   cpu_run_ctrl #(.IMEM_AW(IAW), .DMEM_AW(DAW), .RUN_W(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .imem_cnt(imem_cnt), .dmem_cnt(dmem_cnt),
      .run_cycles(run_cycles), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
      .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable), .addr_ext(addr_ext),
      .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
      .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
      .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s actual=%s required=none", name, what);
   endtask

   // Scoreboard queues, filled by the stimulus, drained by the monitor.
   logic [95:0]  q_iw[$];    // {byte addr, imem word}
   logic [127:0] q_dw[$];    // {byte addr, dmem word}
   logic [63:0]  q_rd[$];    // dump read byte addresses
   logic [63:0]  q_dump[$];  // dump beat data

   logic [63:0] dm [0:(1<<DAW)-1];
   int   mem_n = 0;
   int   en_cnt = 0, en_runs = 0, arst_rises = 0;
   int   stall = 0;
   bit   prev_en = 0, prev_arst = 0, prev_pend = 0;
   logic [63:0] prev_data = '0;

   // Data memory read port, one cycle latency.
   always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= dm[addr_ext_2[DAW+2:3]];

   // Sink: random backpressure, with an optional forced stall on the first beat.
   initial begin
      dump_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stall > 0 && dump_valid) begin
            dump_ready = 1'b0;
            stall--;
         end else begin
            dump_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: compares every host-port pulse and dump beat with the queues,
   // and plays the toy CPU on the data memory.
   always @(negedge clk) begin
      logic [95:0]  ei;
      logic [127:0] ed;
      if (!rst) begin
         if (wen_ext) begin
            if (q_iw.size() == 0) fail_now("imem_wr_extra", "write");
            else begin
               ei = q_iw.pop_front();
               chk("imem_wr_addr", addr_ext, ei[95:32]);
               chk("imem_wr_data", {32'd0, wdata_ext}, {32'd0, ei[31:0]});
            end
         end
         if (wen_ext_2) begin
            dm[addr_ext_2[DAW+2:3]] = wdata_ext_2;
            if (q_dw.size() == 0) fail_now("dmem_wr_extra", "write");
            else begin
               ed = q_dw.pop_front();
               chk("dmem_wr_addr", addr_ext_2, ed[127:64]);
               chk("dmem_wr_data", wdata_ext_2, ed[63:0]);
            end
         end
         if (ren_ext_2) begin
            chk("ren_while_beat_pending", {63'd0, dump_valid}, 64'd0);
            if (q_rd.size() == 0) fail_now("dmem_rd_extra", "read");
            else chk("dmem_rd_addr", addr_ext_2, q_rd.pop_front());
         end
         if (prev_pend) begin
            chk("dump_hold_valid", {63'd0, dump_valid}, 64'd1);
            chk("dump_hold_data", dump_data, prev_data);
         end
         if (dump_valid && dump_ready) begin
            if (q_dump.size() == 0) fail_now("dump_extra", "beat");
            else chk("dump_data", dump_data, q_dump.pop_front());
         end
         prev_pend = dump_valid && !dump_ready;
         prev_data = dump_data;
         if (ld_ready) chk("arst_low_in_load", {63'd0, cpu_arst_n}, 64'd0);
         if (cpu_enable) begin
            chk("arst_high_in_run", {63'd0, cpu_arst_n}, 64'd1);
            if (mem_n != 0) dm[en_cnt % mem_n] = dm[en_cnt % mem_n] + 64'd1;
            en_cnt++;
            if (!prev_en) en_runs++;
         end
         if (cpu_arst_n && !prev_arst) arst_rises++;
         prev_en   = cpu_enable;
         prev_arst = cpu_arst_n;
      end else begin
         prev_pend = 0;
         prev_en   = 0;
         prev_arst = 0;
      end
   end

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctrl"}, 64'({busy, done, ld_ready, dump_valid, cpu_enable, cpu_arst_n,
                               wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
      chk({tag, "_buses"}, addr_ext | addr_ext_2 | {32'd0, wdata_ext} | wdata_ext_2, 64'd0);
   endtask

   // Issue one job; expected traffic comes from the job parameters alone.
   task automatic run_seq(input int ic, input int dc, input int rc, input int stall_n,
                          input bit fixed_i, input bit expect_done);
      logic [63:0] words[$];
      logic [63:0] w;
      int idx, guard, total;
      for (int i = 0; i < ic; i++) begin
         w = fixed_i ? {$urandom(), 32'(10 + i)} : {$urandom(), $urandom()};
         words.push_back(w);
         q_iw.push_back({64'(i * 4), w[31:0]});
      end
      for (int i = 0; i < dc; i++) begin
         w = {$urandom(), $urandom()};
         words.push_back(w);
         q_dw.push_back({64'(i * 8), w});
         q_rd.push_back(64'(i * 8));
         q_dump.push_back(w + 64'(rc / dc + ((i < rc % dc) ? 1 : 0)));
      end
      mem_n = dc; en_cnt = 0; en_runs = 0; arst_rises = 0; stall = stall_n;
      @(posedge clk); #1;
      start = 1'b1; imem_cnt = (IAW+1)'(ic); dmem_cnt = (DAW+1)'(dc); run_cycles = RW'(rc);
      @(posedge clk); #1;
      start = 1'b0; imem_cnt = (IAW+1)'($urandom); dmem_cnt = (DAW+1)'($urandom);
      run_cycles = RW'($urandom);
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      total = words.size(); idx = 0; guard = 0;
      while (idx < total && guard < 500) begin
         start    = (guard == 1 && total >= 2);  // must be ignored while busy
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_data  = words[idx];
         if (ld_valid && ld_ready) idx++;
         @(posedge clk); #1;
         guard++;
      end
      start = 1'b0; ld_valid = 1'b0; ld_data = {$urandom(), $urandom()};
      if (idx < total) fail_now("load_timeout", "stuck");
      if (!expect_done) return;
      guard = 0;
      while (!done && guard < 3000) begin
         ld_valid = 1'($urandom_range(0, 1));  // no effect outside load
         @(posedge clk); #1;
         guard++;
      end
      ld_valid = 1'b0;
      chk("done", {63'd0, done}, 64'd1);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      chk("arst_in_done", {63'd0, cpu_arst_n}, 64'd1);
      chk("enable_cycles", 64'(en_cnt), 64'(rc));
      chk("enable_runs", 64'(en_runs), (rc > 0) ? 64'd1 : 64'd0);
      chk("arst_rises", 64'(arst_rises), 64'd1);
      chk("left_imem_wr", 64'(q_iw.size()), 64'd0);
      chk("left_dmem_wr", 64'(q_dw.size()), 64'd0);
      chk("left_dmem_rd", 64'(q_rd.size()), 64'd0);
      chk("left_dump", 64'(q_dump.size()), 64'd0);
   endtask

   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; imem_cnt = '0; dmem_cnt = '0; run_cycles = '0;
      ld_valid = 1'b0; ld_data = '0;
      for (int i = 0; i < (1 << DAW); i++) dm[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_quiet("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_quiet("idle");

      run_seq(3, 2, 5, 4, 1'b1, 1'b1);   // fixed imem words 0xA..0xC, stalled first dump
      run_seq(0, 0, 0, 0, 1'b0, 1'b1);   // everything skipped
      run_seq(1 << IAW, 1 << DAW, 3, 0, 1'b0, 1'b1);  // full counts, no wrap
      for (int n = 0; n < 10; n++)
         run_seq($urandom_range(0, 1 << IAW), $urandom_range(0, 1 << DAW),
                 $urandom_range(0, 12), $urandom_range(0, 3), 1'b0, 1'b1);

      // Reset in the second enabled cycle of a 10-cycle run.
      run_seq(2, 2, 10, 0, 1'b0, 1'b0);
      guard = 0;
      while (en_cnt < 2 && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      chk("reached_run", 64'(en_cnt), 64'd2);
      rst = 1'b1;
      start = 1'b1;
      #1;
      chk("enable_during_rst", {63'd0, cpu_enable}, 64'd0);
      @(posedge clk); #1;
      chk_quiet("after_rst");
      start = 1'b0;
      q_iw.delete(); q_dw.delete(); q_rd.delete(); q_dump.delete();
      rst = 1'b0;
      @(posedge clk); #1;
      chk_quiet("idle_after_rst");
      run_seq(2, 3, 7, 1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter IMEM_AW, default 9, instruction-memory word-index width.
REQ-002 Parameter DMEM_AW, default 10, data-memory word-index width.
REQ-003 Parameter RUN_W, default 32, run-cycle counter width.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begins a load/run/dump sequence; sampled only in IDLE or DONE.
REQ-007 imem_cnt  in  IMEM_AW+1  instruction words to load; 0..2^IMEM_AW.
REQ-008 dmem_cnt  in  DMEM_AW+1  data words to load and later dump; 0..2^DMEM_AW.
REQ-009 run_cycles  in  RUN_W  cycles cpu_enable is held high.
REQ-010 ld_valid / ld_data  in  1 / 64  load stream; ld_ready  out  1.
REQ-011 dump_valid / dump_data  out  1 / 64  result stream; dump_ready  in  1.
REQ-012 cpu_arst_n  out  1  CPU reset; cpu_enable  out  1  CPU execute enable.
REQ-013 addr_ext  out  64; wen_ext  out  1; ren_ext  out  1; wdata_ext  out  32  instruction-memory host port.
REQ-014 addr_ext_2  out  64; wen_ext_2  out  1; ren_ext_2  out  1; wdata_ext_2  out  64; rdata_ext_2  in  64  data-memory host port.
REQ-015 busy  out  1  high in every state except IDLE and DONE; done  out  1  high in DONE.

Function
REQ-016 States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-017 start in IDLE/DONE latches imem_cnt, dmem_cnt, run_cycles, clears word counter, goes to LOAD_I; start in other states is ignored.
REQ-018 LOAD_I: ld_ready=1; each ld_valid&&ld_ready beat drives wen_ext=1, wdata_ext=ld_data[31:0], addr_ext=index*4 in the same cycle; index increments.
REQ-019 LOAD_I exits to LOAD_D after beat imem_cnt-1; imem_cnt=0 skips directly to LOAD_D with no beat accepted.
REQ-020 LOAD_D: same handshake, wen_ext_2=1, wdata_ext_2=ld_data, addr_ext_2=index*8; exits to RUN after dmem_cnt beats (0 skips).
REQ-021 ld_ready=0 outside LOAD_I/LOAD_D; ld_valid without ld_ready has no effect.
REQ-022 cpu_arst_n=0 in IDLE, LOAD_I, LOAD_D; 1 from RUN entry through DONE.
REQ-023 RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, then DUMP_RD; run_cycles=0 gives zero enable cycles.
REQ-024 cpu_enable=0 in all other states; all host ports (wen/ren) 0 during RUN.
REQ-025 DUMP_RD: ren_ext_2=1, addr_ext_2=index*8 for one cycle; next cycle rdata_ext_2 captured into dump buffer, state DUMP_OUT (one-cycle memory read latency).
REQ-026 DUMP_OUT: dump_valid=1, dump_data stable until dump_ready; on handshake index increments, then DUMP_RD or, after dmem_cnt words, DONE.
REQ-027 dmem_cnt=0 goes RUN to DONE with no dump beat.
REQ-028 Word index widths: DMEM_AW+1 bits; byte address zero-extended to 64 bits; no wrap at full count (2^AW words legal).
REQ-029 Outputs not explicitly driven in a state are 0.

Reset
REQ-030 rst, at any state including mid-load/run/dump, forces IDLE next cycle; counters, latched counts, dump buffer cleared.
REQ-031 During and after reset: busy=0, done=0, ld_ready=0, dump_valid=0, cpu_enable=0, cpu_arst_n=0, all wen/ren 0, all addr/wdata 0.

Structure
REQ-032 State encoding enum and byte-stride constants (4, 8) in shared package cpu_ctrl_pkg.
REQ-033 One sub-module natural: run_counter (loadable down-counter with zero flag) for RUN timing; rest in single FSM module.

Verification
REQ-034 imem_cnt=3, ld words 0xA,0xB,0xC -> wen_ext at addr 0,4,8 with wdata 0xA,0xB,0xC, then LOAD_D.
REQ-035 dmem_cnt=2, run_cycles=5 -> exactly 5 cpu_enable cycles, cpu_arst_n rises on RUN entry, then two dump beats from addr 0,8.
REQ-036 dump_ready held low 4 cycles on first word -> dump_valid stays 1, dump_data unchanged, no second ren_ext_2 issued.
REQ-037 imem_cnt=0, dmem_cnt=0, run_cycles=0 -> IDLE to DONE via skipped states, no write/read/enable pulses.
REQ-038 rst asserted in RUN cycle 2 of 10 -> next cycle IDLE, cpu_enable=0, cpu_arst_n=0; start while busy ignored.
